// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported synchronous SRAM between the CPU instruction-fetch
// port and the data (load/store) port of a unified-memory CPU build. One
// access is accepted per cycle. Data has fixed priority over fetch. The
// winning command is registered onto the SRAM port, and read data is routed
// back to whichever port issued the read, RD_LAT cycles after the command.
//
// Optional feature (compile-time macro MEM_ARB_STARVE_GUARD_EN):
//   When defined, a counter tracks consecutive data grants while a fetch is
//   waiting. Once it reaches STARVE_MAX, the fetch wins the next contended
//   cycle. When undefined, data priority is strict and no counter exists.
//
// Parameters:
//   ADDR_W      byte address width (both requesters and SRAM)
//   DATA_W      data width
//   RD_LAT      SRAM read latency, command cycle -> ram_rdata valid (1..4)
//   STARVE_MAX  data-grant limit before a waiting fetch is forced through
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   if_req/if_addr          fetch request (held until if_gnt)
//   if_gnt                  combinational fetch accept
//   if_rvalid/if_rdata      fetch read response
//   d_req/d_we/d_addr/d_wdata  data request (held until d_gnt)
//   d_gnt                   combinational data accept
//   d_rvalid/d_rdata        data read response (reads only)
//   ram_en/ram_we/ram_addr/ram_wdata  registered SRAM command
//   ram_rdata               SRAM read data
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic grant_if;
    logic grant_d;
    logic force_if;     // fetch overrides data priority this cycle

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    always_comb begin
        force_if = (starve_cnt_q >= CNT_W'(STARVE_MAX));
    end

    // Counts data grants that overtook a waiting fetch. Saturates at the
    // limit; any cycle without a fetch pending, or a fetch grant, restarts it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || grant_if) begin
            starve_cnt_d = '0;
        end else if (grant_d && (starve_cnt_q < CNT_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    always_comb begin
        force_if = 1'b0;
    end
`endif

    // Grants are suppressed while reset is asserted so a requester never
    // believes a command was accepted that the held-in-reset flops drop.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (rst_n) begin
            if (if_req && force_if) begin
                grant_if = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    assign if_gnt = grant_if;
    assign d_gnt  = grant_d;

    // -------------------------------------------------------------------------
    // Registered SRAM command
    // -------------------------------------------------------------------------
    logic              ram_en_q,    ram_en_d;
    logic              ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    // Address and write data hold their previous value on idle cycles to
    // avoid needless toggling on the SRAM pins; ram_en qualifies them.
    always_comb begin
        ram_en_d    = grant_if | grant_d;
        ram_we_d    = grant_d & d_we;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (grant_d) begin
            ram_addr_d  = d_addr;
            ram_wdata_d = d_wdata;
        end else if (grant_if) begin
            ram_addr_d  = if_addr;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

    // -------------------------------------------------------------------------
    // Owner pipeline
    // Stage 0 travels alongside the registered command; stages 1..RD_LAT
    // follow the SRAM's own read latency, so the tag in stage RD_LAT lines up
    // with ram_rdata. Only reads load a valid tag; writes get no response.
    // Owner bit: 1 = data port, 0 = fetch port.
    // -------------------------------------------------------------------------
    logic [RD_LAT:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT:0] tag_own_q, tag_own_d;

    assign tag_vld_d[0] = grant_if | (grant_d & ~d_we);
    assign tag_own_d[0] = grant_d;

    generate
        for (genvar gi = 1; gi <= RD_LAT; gi++) begin : g_tag_shift
            assign tag_vld_d[gi] = tag_vld_q[gi-1];
            assign tag_own_d[gi] = tag_own_q[gi-1];
        end
    endgenerate

    assign if_rvalid = tag_vld_q[RD_LAT] & ~tag_own_q[RD_LAT];
    assign d_rvalid  = tag_vld_q[RD_LAT] &  tag_own_q[RD_LAT];

    // Read data goes to both ports unqualified; rvalid selects the consumer.
    assign if_rdata = ram_rdata;
    assign d_rdata  = ram_rdata;

    // -------------------------------------------------------------------------
    // State registers. Reset discards every in-flight tag so no response can
    // appear after release for a command issued before reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            tag_vld_q   <= '0;
            tag_own_q   <= '0;
        end else begin
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            tag_vld_q   <= tag_vld_d;
            tag_own_q   <= tag_own_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiter instances (RD_LAT = 1 and RD_LAT = 3) share one stimulus
// stream, each with its own behavioural SRAM. The stimulus process predicts
// grants from the priority rules and pushes expected SRAM commands and read
// responses into per-instance queues; per-instance monitors pop and compare
// whenever the DUT shows ram_en or an rvalid.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;
    localparam int N_INST     = 2;
    localparam int MEM_WORDS  = 64;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    typedef struct {
        int          due;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        int          due;
        bit          own_d;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;

    logic          if_gnt    [N_INST];
    logic          d_gnt     [N_INST];
    logic          if_rvalid [N_INST];
    logic          d_rvalid  [N_INST];
    logic          ram_en    [N_INST];
    logic          ram_we    [N_INST];
    logic [DW-1:0] if_rdata  [N_INST];
    logic [DW-1:0] d_rdata   [N_INST];
    logic [AW-1:0] ram_addr  [N_INST];
    logic [DW-1:0] ram_wdata [N_INST];
    logic [DW-1:0] ram_rdata [N_INST];

    cmd_t cmd_q [N_INST][$];
    rsp_t rsp_q [N_INST][$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int idx);
        return 32'h9E37_79B9 * (idx + 1);
    endfunction

    function automatic int lat_of(input int inst);
        return (inst == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h expected=%h",
                     name, inst, cyc, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // DUT instances, SRAM models and monitors
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < N_INST; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 1 : 3;

        logic [31:0] sram    [MEM_WORDS];
        logic [31:0] rd_pipe [LAT];
        bit          init_done = 1'b0;
        cmd_t        mc;
        rsp_t        mr;

        mem_port_arbiter #(
            .ADDR_W    (AW),
            .DATA_W    (DW),
            .RD_LAT    (LAT),
            .STARVE_MAX(STARVE_MAX)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .if_req   (if_req),
            .if_addr  (if_addr),
            .if_gnt   (if_gnt[gi]),
            .if_rvalid(if_rvalid[gi]),
            .if_rdata (if_rdata[gi]),
            .d_req    (d_req),
            .d_we     (d_we),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_gnt    (d_gnt[gi]),
            .d_rvalid (d_rvalid[gi]),
            .d_rdata  (d_rdata[gi]),
            .ram_en   (ram_en[gi]),
            .ram_we   (ram_we[gi]),
            .ram_addr (ram_addr[gi]),
            .ram_wdata(ram_wdata[gi]),
            .ram_rdata(ram_rdata[gi])
        );

        // Behavioural SRAM: data valid LAT cycles after the command cycle.
        always @(posedge clk) begin
            if (!init_done) begin
                for (int i = 0; i < MEM_WORDS; i++) sram[i] <= init_word(i);
                init_done <= 1'b1;
            end else if (ram_en[gi] && ram_we[gi]) begin
                sram[ram_addr[gi][7:2]] <= ram_wdata[gi];
            end
            rd_pipe[0] <= (ram_en[gi] && !ram_we[gi]) ? sram[ram_addr[gi][7:2]]
                                                      : 32'hBAD0_BAD0;
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign ram_rdata[gi] = rd_pipe[LAT-1];

        always @(negedge clk) begin
            if (rst_n) begin
                // SRAM command monitor
                if (cmd_q[gi].size() != 0 && cmd_q[gi][0].due < cyc) begin
                    mc = cmd_q[gi].pop_front();
                    check("cmd_missing", gi, cyc, mc.due);
                end
                if (ram_en[gi]) begin
                    if (cmd_q[gi].size() == 0 || cmd_q[gi][0].due != cyc) begin
                        check("cmd_unexpected", gi, 32'(ram_en[gi]), 32'd0);
                    end else begin
                        mc = cmd_q[gi].pop_front();
                        check("ram_we", gi, 32'(ram_we[gi]), 32'(mc.we));
                        check("ram_addr", gi, ram_addr[gi], mc.addr);
                        if (mc.we) check("ram_wdata", gi, ram_wdata[gi], mc.wdata);
                    end
                end
                // Read response monitor
                if (rsp_q[gi].size() != 0 && rsp_q[gi][0].due < cyc) begin
                    mr = rsp_q[gi].pop_front();
                    check("rsp_missing", gi, cyc, mr.due);
                end
                if (if_rvalid[gi] && d_rvalid[gi]) begin
                    check("rvalid_both", gi, 32'd1, 32'd0);
                end else if (if_rvalid[gi] || d_rvalid[gi]) begin
                    if (rsp_q[gi].size() == 0 || rsp_q[gi][0].due != cyc) begin
                        check("rsp_unexpected", gi, 32'd1, 32'd0);
                    end else begin
                        mr = rsp_q[gi].pop_front();
                        check("rsp_owner", gi, 32'(d_rvalid[gi]), 32'(mr.own_d));
                        check("rsp_data", gi,
                              d_rvalid[gi] ? d_rdata[gi] : if_rdata[gi], mr.data);
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Reference model state and stimulus
    // -------------------------------------------------------------------------
    logic [31:0] ref_mem [MEM_WORDS];
    int          starve_cnt = 0;
    bit          if_drop = 1'b0;
    bit          d_drop  = 1'b0;

    function automatic logic [31:0] rand_addr();
        logic [5:0] w;
        w = 6'($urandom_range(0, MEM_WORDS - 1));
        return {24'h0, w, 2'b00};
    endfunction

    // Start of a cycle: retire requests the model granted last cycle.
    task automatic begin_cycle();
        @(posedge clk);
        #1;
        if (if_drop) if_req = 1'b0;
        if (d_drop)  d_req  = 1'b0;
        if_drop = 1'b0;
        d_drop  = 1'b0;
    endtask

    // Predict the grant from the priority rules, compare, and schedule the
    // SRAM command and any read response for every instance.
    task automatic end_cycle();
        bit exp_if, exp_d;
        exp_if = if_req && (!d_req || (STARVE_ON && starve_cnt >= STARVE_MAX));
        exp_d  = d_req && !exp_if;
        @(negedge clk);
        for (int i = 0; i < N_INST; i++) begin
            check("if_gnt", i, 32'(if_gnt[i]), 32'(exp_if));
            check("d_gnt",  i, 32'(d_gnt[i]),  32'(exp_d));
        end
        if (exp_d) begin
            for (int i = 0; i < N_INST; i++)
                cmd_q[i].push_back('{due: cyc + 1, we: d_we, addr: d_addr, wdata: d_wdata});
            if (d_we) begin
                ref_mem[d_addr[7:2]] = d_wdata;
            end else begin
                for (int i = 0; i < N_INST; i++)
                    rsp_q[i].push_back('{due: cyc + 1 + lat_of(i), own_d: 1'b1,
                                         data: ref_mem[d_addr[7:2]]});
            end
            d_drop = 1'b1;
        end else if (exp_if) begin
            for (int i = 0; i < N_INST; i++) begin
                cmd_q[i].push_back('{due: cyc + 1, we: 1'b0, addr: if_addr, wdata: 32'h0});
                rsp_q[i].push_back('{due: cyc + 1 + lat_of(i), own_d: 1'b0,
                                     data: ref_mem[if_addr[7:2]]});
            end
            if_drop = 1'b1;
        end
        if (!if_req || exp_if) starve_cnt = 0;
        else if (exp_d)        starve_cnt++;
    endtask

    task automatic rand_cycle(input int wr_pct);
        begin_cycle();
        if (!if_req && $urandom_range(0, 99) < 60) begin
            if_req  = 1'b1;
            if_addr = rand_addr();
        end
        if (!d_req && $urandom_range(0, 99) < 60) begin
            d_req   = 1'b1;
            d_we    = ($urandom_range(0, 99) < wr_pct);
            d_addr  = rand_addr();
            d_wdata = $urandom();
        end
        end_cycle();
    endtask

    task automatic set_if(input logic [31:0] a);
        if (!if_req) begin
            if_req  = 1'b1;
            if_addr = a;
        end
    endtask

    task automatic set_d(input bit we, input logic [31:0] a, input logic [31:0] wd);
        if (!d_req) begin
            d_req   = 1'b1;
            d_we    = we;
            d_addr  = a;
            d_wdata = wd;
        end
    endtask

    task automatic idle_until_drained();
        for (int k = 0; k < 10 && (if_req || d_req); k++) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < N_INST; i++) begin
            check("rst_if_gnt",    i, 32'(if_gnt[i]),    32'd0);
            check("rst_d_gnt",     i, 32'(d_gnt[i]),     32'd0);
            check("rst_ram_en",    i, 32'(ram_en[i]),    32'd0);
            check("rst_ram_we",    i, 32'(ram_we[i]),    32'd0);
            check("rst_ram_addr",  i, ram_addr[i],       32'd0);
            check("rst_ram_wdata", i, ram_wdata[i],      32'd0);
            check("rst_if_rvalid", i, 32'(if_rvalid[i]), 32'd0);
            check("rst_d_rvalid",  i, 32'(d_rvalid[i]),  32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;

        // Reset: requests asserted to show grants are held off.
        repeat (2) @(posedge clk);
        #1;
        if_req = 1'b1;
        d_req  = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req  = 1'b0;
        rst_n  = 1'b1;

        // Lone fetch read.
        begin_cycle(); set_if(32'h10); end_cycle();
        begin_cycle(); end_cycle();
        // Simultaneous requests: data first, fetch next cycle.
        begin_cycle(); set_d(1'b0, 32'h20, 32'h0); set_if(32'h24); end_cycle();
        begin_cycle(); end_cycle();
        // Write then read back the same word on consecutive cycles.
        begin_cycle(); set_d(1'b1, 32'h30, 32'hA5A5_A5A5); end_cycle();
        begin_cycle(); set_d(1'b0, 32'h30, 32'h0); end_cycle();
        idle_until_drained();

        // Alternating data/fetch reads every cycle.
        for (int k = 0; k < 12; k++) begin
            begin_cycle();
            if (k % 2 == 0) set_d(1'b0, rand_addr(), 32'h0);
            set_if(rand_addr());
            end_cycle();
        end
        idle_until_drained();

        // Random traffic.
        for (int k = 0; k < 300; k++) rand_cycle(35);
        idle_until_drained();

        // Reset with two reads in flight.
        begin_cycle(); set_d(1'b0, rand_addr(), 32'h0); end_cycle();
        begin_cycle(); set_d(1'b0, rand_addr(), 32'h0); set_if(rand_addr()); end_cycle();
        begin_cycle();
        rst_n = 1'b0;
        set_d(1'b0, rand_addr(), 32'h0);
        for (int i = 0; i < N_INST; i++) begin
            cmd_q[i].delete();
            rsp_q[i].delete();
        end
        starve_cnt = 0;
        @(negedge clk);
        check_reset_outputs();
        begin_cycle();
        rst_n = 1'b1;
        end_cycle();
        idle_until_drained();

        // Saturated contention: both ports request every cycle.
        for (int k = 0; k < 20; k++) begin
            begin_cycle();
            set_d(1'b0, rand_addr(), 32'h0);
            set_if(rand_addr());
            end_cycle();
        end
        idle_until_drained();

        for (int k = 0; k < 100; k++) rand_cycle(50);
        idle_until_drained();
        for (int k = 0; k < 8; k++) begin
            begin_cycle();
            end_cycle();
        end
        for (int i = 0; i < N_INST; i++) begin
            check("cmd_q_empty", i, cmd_q[i].size(), 32'd0);
            check("rsp_q_empty", i, rsp_q[i].size(), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
